digit_scan_controller: RTL

- Time-multiplexing scheduler for a 4-digit common-anode seven-segment display.
- Replaces the bare free-running 2-bit phase counter with a prescaled, enable-gated digit sequencer.
- Each digit gets a blanking (dead) interval and then a drive interval; the controller owns digit select, anode enables and segment data.
- Sits between the display-value register file and the board display pins.

---
 rtl/disp_pkg.sv | 7 +
 rtl/hex_to_seg.sv | 27 ++
 rtl/digit_scan_controller.sv | 100 ++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared scan states and display constants for the digit scan controller.
package disp_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam int NUM_DIGITS = 4;
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: 4-bit nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module hex_to_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);
  always_comb begin
    seg_n = 7'b1111111;
    case (nibble)
      4'h0: seg_n = 7'b1000000;
      4'h1: seg_n = 7'b1111001;
      4'h2: seg_n = 7'b0100100;
      4'h3: seg_n = 7'b0110000;
      4'h4: seg_n = 7'b0011001;
      4'h5: seg_n = 7'b0010010;
      4'h6: seg_n = 7'b0000010;
      4'h7: seg_n = 7'b1111000;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0010000;
      4'ha: seg_n = 7'b0001000;
      4'hb: seg_n = 7'b0000011;
      4'hc: seg_n = 7'b1000110;
      4'hd: seg_n = 7'b0100001;
      4'he: seg_n = 7'b0000110;
      default: seg_n = 7'b0001110;
    endcase
  end
endmodule

// File: rtl/digit_scan_controller.sv
// digit_scan_controller: prescaled blank/drive scanner for a 4-digit common-anode display.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module digit_scan_controller
  import disp_pkg::*;
#(
  parameter int DRIVE_TICKS = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  logic        clk,
  input  logic        state_reset,
  input  logic        enable,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_mask,
  output logic [3:0]  anode_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [1:0]  digit_sel,
  output logic        frame_done
);
  localparam int CW = $clog2(((DRIVE_TICKS > BLANK_TICKS) ? DRIVE_TICKS : BLANK_TICKS) + 1);
  scan_state_t state;
  logic [1:0] idx;
  logic [CW-1:0] cnt;
  logic [15:0] snapshot;
  logic [NUM_DIGITS-1:0] dp_snap, mask_snap, lz, hide;
  logic [3:0] nib;
  logic [6:0] seg;
  assign nib = snapshot[{idx, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
  assign lz = {~|snapshot[15:12], ~|snapshot[15:8], ~|snapshot[15:4], 1'b0};
`else
  assign lz = '0;
`endif
  assign hide = mask_snap | lz;
  hex_to_seg u_dec (.nibble(nib), .seg_n(seg));
  always_ff @(posedge clk) begin
    if (state_reset) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      snapshot <= '0;
      dp_snap <= '0;
      mask_snap <= '0;
      anode_n <= ANODE_OFF;
      seg_n <= SEG_OFF;
      dp_n <= 1'b1;
      digit_sel <= '0;
      frame_done <= 1'b0;
    end else if (!enable) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      anode_n <= ANODE_OFF;
      seg_n <= SEG_OFF;
      dp_n <= 1'b1;
      digit_sel <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          state <= BLANK;
          idx <= '0;
          cnt <= '0;
          snapshot <= digits_in;
          dp_snap <= dp_in;
          mask_snap <= digit_mask;
          digit_sel <= '0;
        end
        BLANK: begin
          cnt <= (cnt == CW'(BLANK_TICKS - 1)) ? '0 : cnt + 1'b1;
          if (cnt == CW'(BLANK_TICKS - 1)) begin
            state <= DRIVE;
            anode_n <= hide[idx] ? ANODE_OFF : ~(4'b0001 << idx);
            seg_n <= seg;
            dp_n <= ~dp_snap[idx] | lz[idx];
          end
        end
        default: begin
          cnt <= (cnt == CW'(DRIVE_TICKS - 1)) ? '0 : cnt + 1'b1;
          if (cnt == CW'(DRIVE_TICKS - 1)) begin
            state <= BLANK;
            idx <= idx + 2'd1;
            digit_sel <= idx + 2'd1;
            anode_n <= ANODE_OFF;
            seg_n <= SEG_OFF;
            dp_n <= 1'b1;
            if (idx == 2'd3) begin
              frame_done <= 1'b1;
              snapshot <= digits_in;
              dp_snap <= dp_in;
              mask_snap <= digit_mask;
            end
          end
        end
      endcase
    end
  end
endmodule
